// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles every handshake, bus and side-band signal of the MEM
// stage except clk/reset.
//   slave  : the MEM stage itself
//   master : the surrounding pipeline (EX, WB, data SRAM)
// Handshake rule used on both sides of the stage: a transfer happens at a
// rising edge where the producer's valid and the consumer's allowin are both
// high. Valid is never made to depend on the consumer's allowin.
// Payload convention: payload[EXC_W-1] is the exception flag and
// payload[EXC_W-2] is the ertn flag. All other payload bits are opaque.
interface mem_stage_if #(
   parameter int EXC_W = 103
);
   logic                    es2ms_valid;
   logic [64+EXC_W+44:0]    es2ms_bus;
   logic                    es_req_outstanding;
   logic                    ms_allowin;
   logic                    ms2ws_valid;
   logic                    ws_allowin;
   logic [64+EXC_W-1:0]     ms2ws_bus;
   logic [38:0]             ms_rf_zip;
   logic                    data_sram_data_ok;
   logic [31:0]             data_sram_rdata;
   logic                    ws_flush;
   logic                    ms_ex;
   logic [38:0]             ms_fwd_zip;

   modport master (
      output es2ms_valid, es2ms_bus, es_req_outstanding, ws_allowin,
             data_sram_data_ok, data_sram_rdata, ws_flush,
      input  ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip, ms_ex, ms_fwd_zip
   );

   modport slave (
      input  es2ms_valid, es2ms_bus, es_req_outstanding, ws_allowin,
             data_sram_data_ok, data_sram_rdata, ws_flush,
      output ms_allowin, ms2ws_valid, ms2ws_bus, ms_rf_zip, ms_ex, ms_fwd_zip
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
// Latches the EX bundle, waits for the data-SRAM response of a load/store,
// aligns and extends load data, and hands the result to WB. Responses that
// belong to instructions killed by a WB flush are counted and dropped.
// Optional feature macro: MS_RDATA_BUF_EN -- when defined, a response that
// arrives while WB is stalled is captured in a one-entry buffer; when
// undefined, WB must keep ws_allowin high whenever a response can arrive.
module mem_stage #(
   parameter int EXC_W = 103
) (
   input  logic       clk,
   input  logic       reset,
   mem_stage_if.slave bus
);

   // EX bundle fields
   logic [31:0]      es_vaddr;
   logic [31:0]      es_pc;
   logic [EXC_W-1:0] es_payload;
   logic             es_csr_re;
   logic             es_rf_we;
   logic [4:0]       es_rf_waddr;
   logic [31:0]      es_result;
   logic             es_mem_req;
   logic [4:0]       es_ld_op;

   assign {es_vaddr, es_pc, es_payload, es_csr_re, es_rf_we, es_rf_waddr,
           es_result, es_mem_req, es_ld_op} = bus.es2ms_bus;

   // Latched MEM-stage state
   logic             ms_valid;
   logic [31:0]      ms_vaddr;
   logic [31:0]      ms_pc;
   logic [EXC_W-1:0] ms_payload;
   logic             ms_csr_re;
   logic             ms_rf_we;
   logic [4:0]       ms_rf_waddr;
   logic [31:0]      ms_result;
   logic             ms_mem_req;
   logic [4:0]       ms_ld_op;

   // Control
   logic             ms_ready_go;
   logic             ms_allowin;
   logic             ms2ws_valid;
   logic             resp_hit;
   logic             is_load;
   logic             ms_blocking;
   logic             handover;
   logic             payload_we;

   // Discard counter for responses owed to killed instructions
   logic [1:0]       discard_cnt;
   logic [1:0]       discard_nxt;
   logic             disc_dec;
   logic [1:0]       disc_inc;

   // Read-data buffer
   logic             buf_valid;
   logic [31:0]      buf_data;

   // Load data path
   logic [31:0]      rdata_src;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      load_data;
   logic [31:0]      rf_wdata;

   // A response only belongs to MEM when no killed request is still owed one
   assign resp_hit    = bus.data_sram_data_ok & (discard_cnt == 2'd0);
   assign ms_ready_go = ~ms_mem_req | resp_hit | buf_valid;
   assign ms_allowin  = ~ms_valid | (ms_ready_go & bus.ws_allowin);
   assign ms2ws_valid = ms_valid & ms_ready_go & ~bus.ws_flush;
   assign handover    = ms2ws_valid & bus.ws_allowin;
   assign payload_we  = bus.es2ms_valid & ms_allowin & ~bus.ws_flush;
   assign is_load     = |ms_ld_op;
   assign ms_blocking = ms_valid & is_load & ~ms_ready_go;

   // Valid bit: reset, then flush, then normal pipeline advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (bus.ws_flush) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= bus.es2ms_valid;
      end
   end

   // Payload registers capture the EX bundle on an accepted, unflushed transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_vaddr    <= 32'd0;
         ms_pc       <= 32'd0;
         ms_payload  <= '0;
         ms_csr_re   <= 1'b0;
         ms_rf_we    <= 1'b0;
         ms_rf_waddr <= 5'd0;
         ms_result   <= 32'd0;
         ms_mem_req  <= 1'b0;
         ms_ld_op    <= 5'd0;
      end else if (payload_we) begin
         ms_vaddr    <= es_vaddr;
         ms_pc       <= es_pc;
         ms_payload  <= es_payload;
         ms_csr_re   <= es_csr_re;
         ms_rf_we    <= es_rf_we;
         ms_rf_waddr <= es_rf_waddr;
         ms_result   <= es_result;
         ms_mem_req  <= es_mem_req;
         ms_ld_op    <= es_ld_op;
      end
   end

   // A flush owes one dropped response for MEM's unanswered request and one
   // for a request EX already handshook; a response in the flush cycle itself
   // satisfies MEM's request, so it is not counted.
   assign disc_dec    = bus.data_sram_data_ok & (discard_cnt != 2'd0);
   assign disc_inc    = bus.ws_flush
                        ? ({1'b0, ms_valid & ms_mem_req & ~resp_hit & ~buf_valid}
                           + {1'b0, bus.es_req_outstanding})
                        : 2'd0;
   assign discard_nxt = discard_cnt - {1'b0, disc_dec} + disc_inc;

   // Discard counter: decrement on a dropped response, add owed responses on flush
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         discard_cnt <= 2'd0;
      end else begin
         discard_cnt <= discard_nxt;
      end
   end

`ifdef MS_RDATA_BUF_EN
   // Hold a response that arrives while WB is stalled until MEM hands over
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_data  <= 32'd0;
      end else if (bus.ws_flush || handover) begin
         buf_valid <= 1'b0;
      end else if (ms_valid && ms_mem_req && resp_hit && !bus.ws_allowin && !buf_valid) begin
         buf_valid <= 1'b1;
         buf_data  <= bus.data_sram_rdata;
      end
   end
`else
   assign buf_valid = 1'b0;
   assign buf_data  = 32'd0;

   // Without a buffer a response can only be consumed if WB accepts it at once
   a_no_resp_while_wb_stalled : assert property (
      @(posedge clk) disable iff (reset) !(resp_hit && !bus.ws_allowin))
      else $error("mem_stage: data_ok accepted while ws_allowin is low");
`endif

   assign rdata_src = buf_valid ? buf_data : bus.data_sram_rdata;

   // Select the addressed byte/halfword and extend per load opcode {b,h,w,bu,hu}
   always_comb begin
      ld_byte   = rdata_src[7:0];
      ld_half   = rdata_src[15:0];
      load_data = rdata_src;
      case (ms_vaddr[1:0])
         2'd0:    ld_byte = rdata_src[7:0];
         2'd1:    ld_byte = rdata_src[15:8];
         2'd2:    ld_byte = rdata_src[23:16];
         default: ld_byte = rdata_src[31:24];
      endcase
      ld_half = ms_vaddr[1] ? rdata_src[31:16] : rdata_src[15:0];
      if (ms_ld_op[4]) begin
         load_data = {{24{ld_byte[7]}}, ld_byte};
      end else if (ms_ld_op[3]) begin
         load_data = {{16{ld_half[15]}}, ld_half};
      end else if (ms_ld_op[2]) begin
         load_data = rdata_src;
      end else if (ms_ld_op[1]) begin
         load_data = {24'd0, ld_byte};
      end else if (ms_ld_op[0]) begin
         load_data = {16'd0, ld_half};
      end
   end

   assign rf_wdata = is_load ? load_data : ms_result;

   // Outputs to EX, WB and the ID bypass network
   assign bus.ms_allowin  = ms_allowin;
   assign bus.ms2ws_valid = ms2ws_valid;
   assign bus.ms2ws_bus   = {ms_vaddr, ms_pc, ms_payload};
   assign bus.ms_rf_zip   = {ms_csr_re, ms_rf_we, ms_rf_waddr, rf_wdata};
   assign bus.ms_ex       = ms_valid & (ms_payload[EXC_W-1] | ms_payload[EXC_W-2]);
   assign bus.ms_fwd_zip  = {ms_blocking, ms_rf_we & ms_valid, ms_rf_waddr, rf_wdata};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. Latches the EX bundle and waits for the data-SRAM response of a load or store. Aligns and extends load data, then presents `ms2ws_bus` / `ms_rf_zip` to WB. Drops SRAM responses that belong to instructions killed by a WB flush, and supplies bypass info to ID.

## Interface
- `EXC_W`, default 103: width of the opaque exception/CSR/TLB payload forwarded unchanged to WB.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `es2ms_valid` in 1: EX holds a valid instruction.
- `es2ms_bus` in 64+EXC_W+45: {es_vaddr[31:0], es_pc[31:0], payload[EXC_W-1:0], es_csr_re, es_rf_we, es_rf_waddr[4:0], es_result[31:0], es_mem_req, es_ld_op[4:0]}.
  - `es_ld_op` is one-hot {b, h, w, bu, hu}; all zero means not a load.
  - `es_mem_req` = 1 means the SRAM request handshake completed in EX.
- `es_req_outstanding` in 1: EX holds a handshaken request not yet passed to MEM.
- `ms_allowin` out 1: MEM can accept from EX.
- `ms2ws_valid` out 1: `ms_valid & ms_ready_go`.
- `ws_allowin` in 1: WB can accept.
- `ms2ws_bus` out 64+EXC_W: {ms_vaddr, ms_pc, payload}.
- `ms_rf_zip` out 39: {csr_re, rf_we, rf_waddr, rf_wdata}.
- `data_sram_data_ok` in 1: one-cycle response pulse.
- `data_sram_rdata` in 32: response data.
- `ws_flush` in 1: wb_ex | ertn_flush | wb_refetch_flush.
- `ms_ex` out 1: MEM holds a valid instruction whose payload flags an exception or ertn; EX must suppress new stores.
- `ms_fwd_zip` out 39: {ms_blocking, rf_we & ms_valid, rf_waddr, rf_wdata}.
  - `ms_blocking` = `ms_valid & load & ~ms_ready_go`.

## Operation
- `ms_valid` updates as follows, in priority order:
  - `reset` clears it to 0.
  - `ws_flush` clears it to 0.
  - Otherwise, if `ms_allowin`, it loads `es2ms_valid`.
- Payload registers load on `es2ms_valid & ms_allowin & ~ws_flush`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_ready_go = ~ms_mem_req | resp_hit | buf_valid`.
  - `resp_hit = data_sram_data_ok & (discard_cnt == 0)`.
- Load data alignment, with `a = ms_vaddr[1:0]`:
  - ld.b: byte `a`, sign-extended.
  - ld.bu: byte `a`, zero-extended.
  - ld.h: halfword `a[1]`, sign-extended.
  - ld.hu: halfword `a[1]`, zero-extended.
  - ld.w: all 32 bits.
  - Non-load: `rf_wdata = ms_result`.
- The data source is `buf_valid ? buf_data : data_sram_rdata`.
- `rf_we` is forwarded as latched; WB does the exception gating.
- Discard counter `discard_cnt` (2 bits, reset 0):
  - Decrements by 1 on `data_sram_data_ok` when nonzero. That response is consumed, never used.
  - On `ws_flush`, adds `(ms_valid & ms_mem_req & ~resp_hit & ~buf_valid) + es_req_outstanding`.
  - Both actions apply in the same cycle when simultaneous.
  - Maximum value is 2; overflow is a bench assertion failure.
- `resp_hit` in the flush cycle completes the killed instruction's request, so no increment is made for it.

## Timing
- EX accepted at edge N gives `ms_valid` = 1 after N.
- With no memory request, `ms2ws_valid` = 1 in the same cycle and WB captures at edge N+1.
- With a memory request, `ms2ws_valid` rises combinationally in the `data_ok` cycle.
- Reset values:
  - `ms_valid`, `buf_valid`, `discard_cnt`, all payload registers: 0.
  - `ms2ws_valid`, `ms_ex`, `ms_fwd_zip`: 0.
  - `ms_allowin`: 1.
- `ms2ws_valid` is forced to 0 in any cycle with `ws_flush`.
- `reset` asserted mid-wait returns everything to reset values immediately. `data_ok` pulses during reset are ignored.

## Configuration
- `MS_RDATA_BUF_EN` defined:
  - `resp_hit` while `~ws_allowin` sets `buf_valid` and captures `buf_data`.
  - `buf_valid` clears when MEM hands over to WB, or on flush.
- `MS_RDATA_BUF_EN` undefined:
  - No buffer; `buf_valid` is tied to 0.
  - WB must hold `ws_allowin` = 1. A `resp_hit` with `ws_allowin` = 0 triggers a simulation `$error`.

## Test plan
- ld.b with vaddr=0x...3 and rdata=0x80FF_1234: response completes -> `rf_wdata`=0xFFFF_FF80. ld.bu -> 0x0000_0080. ld.hu with a=2 -> 0x0000_80FF.
- Non-memory add with result 0x1234: accepted -> `ms2ws_valid` next cycle, `ms_rf_zip`={0,1,waddr,0x1234}, `ms_fwd_zip` blocking=0.
- Load waits 3 cycles for `data_ok`: `ms_allowin`=0 and `ms_blocking`=1 throughout; both release in the `data_ok` cycle.
- `ws_flush` while the MEM load is pending and `es_req_outstanding`=1 -> `discard_cnt`=2. The next two `data_ok` pulses are dropped. A third `data_ok` completes a newly issued load.
- `ws_flush` coincident with a `data_ok` for the MEM load -> `discard_cnt` stays 0 and `ms2ws_valid`=0.
- With `MS_RDATA_BUF_EN`: `data_ok` while `ws_allowin`=0 for 2 cycles -> data is held and delivered intact when `ws_allowin` rises.
